mem_arbiter: RTL

Shares the single-ported 4096×32 word memory between the core's instruction-fetch port and its load/store port. Each cycle it grants at most one requester, drives the memory, and routes the one-cycle-latency read data back to the owner. Data accesses have priority, with an aging counter that prevents fetch starvation. It sits between the CPU state machine and the block-RAM array, replacing direct `MEM[PC]` indexing.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_age_counter.sv | 37 +++
 rtl/mem_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Types and default widths for the fetch/load-store memory arbiter.
// The width defaults are also used by the core.
package mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 12;
    localparam int unsigned ARB_DATA_W = 32;

    // Which port owns the read data that comes back this cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating count of consecutive denied fetch cycles.
// When LIMIT is 0 there is no counter and expired stays low.
module arb_age_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CW = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

    generate
        if (LIMIT == 0) begin : g_off
            logic unused_ctrl;
            assign unused_ctrl = inc ^ clr ^ clk ^ resetn;
            assign expired     = 1'b0;
        end else begin : g_on
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (inc && (cnt != CW'(LIMIT))) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expired = (cnt >= CW'(LIMIT));
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported word memory between instruction fetch and load/store.
// Data wins contention unless the fetch aging counter has expired.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ARB_ADDR_W,
    parameter int unsigned DATA_W       = ARB_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    output logic                  m_en,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata
);

    owner_t owner;
    owner_t owner_nxt;
    logic   age_expired;
    logic   fetch_win;
    logic   data_win;

    arb_age_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_age (
        .clk     (clk),
        .resetn  (resetn),
        .inc     (i_req & ~i_gnt),
        .clr     (i_gnt | ~i_req),
        .expired (age_expired)
    );

    // Grants are gated by resetn so nothing reaches the memory during reset.
    always_comb begin
        fetch_win = i_req & (~d_req | age_expired);
        data_win  = d_req & ~fetch_win;
        i_gnt     = resetn & fetch_win;
        d_gnt     = resetn & data_win;
    end

    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_addr  = i_gnt ? i_addr : d_addr;
        m_be    = (d_gnt && d_we) ? d_be : '0;
        m_wdata = d_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner <= IDLE;
        end else begin
            owner <= owner_nxt;
        end
    end

    always_comb begin
        owner_nxt = IDLE;
        if (i_gnt) begin
            owner_nxt = FETCH;
        end else if (d_gnt && !d_we) begin
            owner_nxt = LOAD;
        end
    end

    always_comb begin
        i_rvalid = (owner == FETCH);
        d_rvalid = (owner == LOAD);
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end

endmodule
